nav_position_unit: RTL and testbench
====================================

# nav_position_unit

Parametrised N-axis position integrator for the command module's navigation path. Each cycle it derives per-axis signed velocity from the requested speed and the ship's combat mode, then integrates position with saturation. It adds a charged jump sequence with a request/busy/done handshake and a cooldown window. It sits between mode control, which drives `ship_mode`, `pos_mode` and jump requests, and the downstream position consumers.

## Interface
- `K`, 16: bits per axis; position, speed and velocity are signed two's complement.
- `N`, 3: number of axes; axis i occupies bits [(i+1)*K-1 : i*K], with axis 0 = X.
- `CHARGE`, 8: jump charge cycles, >= 1.
- `COOLDOWN`, 4: cycles after a jump during which requests are ignored, >= 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ship_mode`  in  4  one-hot: 0001 stop, 0010 attack, 0100 defense, 1000 stealth.
- `pos_mode`  in  4  one-hot: 0001 zero, 0010 normal (integrate), 0100 hold; any other value is treated as hold.
- `speed`  in  N*K  per-axis requested speed, signed.
- `jump_position`  in  N*K  per-axis jump target, signed; sampled only when a request is accepted.
- `jump_req`  in  1  level jump request.
- `velocity`  out  N*K  per-axis scaled velocity; combinational.
- `position`  out  N*K  per-axis registered position.
- `jump_busy`  out  1  high while a jump is charging.
- `jump_done`  out  1  single-cycle pulse; high in the first cycle the target is visible on `position`.
- `sat`  out  N  sticky per-axis saturation flags.

## Operation
- Velocity per axis is an arithmetic shift of `speed`:
  - attack: `speed`.
  - defense: `speed` >>> 1.
  - stealth: `speed` >>> 2.
  - stop, or any `ship_mode` that is not exactly one-hot: 0.
- Shifts are sign-preserving and round toward negative infinity, so -3 >>> 1 = -2.
- Normal integration: next = position + velocity, computed at K+1 bits.
  - If the result exceeds 2^(K-1)-1, clamp to 2^(K-1)-1 and set that axis's `sat` bit.
  - If the result is below -2^(K-1), clamp to -2^(K-1) and set that axis's `sat` bit.
  - Position never wraps.
- `sat` bits are sticky. They clear only on `reset` or `pos_mode` = zero.
- Jump FSM states: IDLE, CHARGE, COOL.
  - IDLE to CHARGE: on an edge with `jump_req`=1 and `pos_mode` not zero. At that edge, capture `jump_position` into an internal target and load the charge counter with CHARGE-1.
  - CHARGE: `jump_busy`=1 and all axes hold position regardless of `pos_mode` normal/hold. The counter decrements each edge. At the edge where the counter is 0, load target into `position`, pulse `jump_done`, and go to COOL, or to IDLE if COOLDOWN=0. The load does not affect `sat`.
  - COOL: lasts COOLDOWN cycles. `jump_req` is ignored and `pos_mode` operates normally. Then go to IDLE.
- Per-edge priority, highest first:
  1. `reset`.
  2. `pos_mode` = zero: position 0, `sat` 0, FSM to IDLE, which aborts a charge with no `jump_done`.
  3. Jump load.
  4. Charge hold.
  5. Normal integration or hold.
- Changes to `jump_position` after acceptance have no effect on the jump in flight.

## Timing
- Reset values: `position`=0, `sat`=0, `jump_busy`=0, `jump_done`=0, FSM in IDLE, counters 0.
  - Reset asserted mid-charge aborts the jump immediately.
- `velocity` is combinational from `speed` and `ship_mode`, so `position` reflects the inputs one edge later.
- Call the acceptance edge E0.
  - `jump_busy` is high for exactly CHARGE cycles, following E0 through E_CHARGE.
  - The target appears on `position`, and `jump_done`=1, in the cycle after E_CHARGE.
  - The earliest next acceptance is edge E_(CHARGE+COOLDOWN+1).
- `jump_req` held high through COOL starts a new charge on the first edge in IDLE.

## Test plan
- Reset and integrate:
  - Stimulus: `reset`, then `ship_mode`=0010, `pos_mode`=0010, speed X=5, Y=-3, Z=0 for 4 edges.
  - Response: position X=20, Y=-12, Z=0; `sat`=0.
- Mode scaling:
  - Stimulus: speed X=7, Y=-3, Z=-8.
  - Response: defense velocity = 3, -2, -4; stealth velocity = 1, -1, -2; `ship_mode`=0011 gives velocity all 0.
- Saturation:
  - Stimulus: X at 32760, attack, speed X=10.
  - Response: X=32767 and `sat`[0]=1 after 1 edge; `sat`[0] stays 1 after speed changes to -10 (X=32757); `pos_mode`=0001 clears it and X to 0.
- Jump handshake:
  - Stimulus: CHARGE=8, COOLDOWN=4, X=100, speed 1, `jump_req` pulsed with target X=-500.
  - Response: `jump_busy` high for 8 cycles with X held at 100; then X=-500 with `jump_done` high for 1 cycle.
  - Response: a `jump_req` pulse 2 cycles later is ignored; X integrates -499, -498, ….
- Abort:
  - Stimulus: `pos_mode`=0001 at charge cycle 3.
  - Response: position 0, `jump_busy`=0, and no `jump_done`.
  - Stimulus, repeated: async `reset` mid-charge.
  - Response: same values with no clock edge required.
- Hold and invalid mode:
  - Stimulus: `pos_mode`=0100, then `pos_mode`=0110, with speed 9.
  - Response: position unchanged in both cases.

Source files
------------

// File: rtl/nav_position_unit.sv
// N-axis position integrator with saturating accumulation, mode-scaled velocity
// and a charged jump sequence (IDLE -> CHARGE -> COOL) with a cooldown window.
module nav_position_unit #(
  parameter int unsigned K        = 16,
  parameter int unsigned N        = 3,
  parameter int unsigned CHARGE   = 8,
  parameter int unsigned COOLDOWN = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     ship_mode,
  input  logic [3:0]     pos_mode,
  input  logic [N*K-1:0] speed,
  input  logic [N*K-1:0] jump_position,
  input  logic           jump_req,
  output logic [N*K-1:0] velocity,
  output logic [N*K-1:0] position,
  output logic           jump_busy,
  output logic           jump_done,
  output logic [N-1:0]   sat
);

  localparam int unsigned CntMax = (CHARGE > COOLDOWN) ? CHARGE : COOLDOWN;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] ChargeLd = CntW'(CHARGE - 1);
  localparam logic [CntW-1:0] CoolLd   = CntW'((COOLDOWN == 0) ? 0 : COOLDOWN - 1);
  localparam logic signed [K-1:0] PosMax = {1'b0, {(K-1){1'b1}}};
  localparam logic signed [K-1:0] PosMin = {1'b1, {(K-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCharge, StCool} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [N-1:0]        sat_q, sat_d;
  logic signed [K-1:0] pos_q [N];
  logic signed [K-1:0] pos_d [N];
  logic signed [K-1:0] tgt_q [N];
  logic signed [K-1:0] tgt_d [N];
  logic signed [K-1:0] spd [N];
  logic signed [K-1:0] vel [N];
  logic signed [K:0]   sum [N];

  // Velocity scaling and the widened sum used for overflow detection.
  always_comb begin
    velocity = '0;
    position = '0;
    for (int i = 0; i < N; i++) begin
      spd[i] = $signed(speed[i*K +: K]);
      case (ship_mode)
        4'b0010: vel[i] = spd[i];
        4'b0100: vel[i] = spd[i] >>> 1;
        4'b1000: vel[i] = spd[i] >>> 2;
        default: vel[i] = '0;
      endcase
      velocity[i*K +: K] = vel[i];
      position[i*K +: K] = pos_q[i];
      sum[i] = {pos_q[i][K-1], pos_q[i]} + {vel[i][K-1], vel[i]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    sat_d   = sat_q;
    for (int i = 0; i < N; i++) begin
      pos_d[i] = pos_q[i];
      tgt_d[i] = tgt_q[i];
    end

    if (pos_mode == 4'b0001) begin
      state_d = StIdle;
      cnt_d   = '0;
      sat_d   = '0;
      for (int i = 0; i < N; i++) pos_d[i] = '0;
    end else if (state_q == StCharge) begin
      if (cnt_q == '0) begin
        done_d = 1'b1;
        for (int i = 0; i < N; i++) pos_d[i] = tgt_q[i];
        if (COOLDOWN == 0) begin
          state_d = StIdle;
        end else begin
          state_d = StCool;
          cnt_d   = CoolLd;
        end
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end else begin
      if (pos_mode == 4'b0010) begin
        for (int i = 0; i < N; i++) begin
          // Sign bits disagree only when the K+1 bit sum left the K-bit range.
          if (sum[i][K] != sum[i][K-1]) begin
            pos_d[i] = sum[i][K] ? PosMin : PosMax;
            sat_d[i] = 1'b1;
          end else begin
            pos_d[i] = sum[i][K-1:0];
          end
        end
      end
      if (state_q == StIdle) begin
        if (jump_req) begin
          state_d = StCharge;
          cnt_d   = ChargeLd;
          for (int i = 0; i < N; i++) tgt_d[i] = $signed(jump_position[i*K +: K]);
        end
      end else if (cnt_q == '0) begin
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      sat_q   <= '0;
      for (int i = 0; i < N; i++) begin
        pos_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
      for (int i = 0; i < N; i++) begin
        pos_q[i] <= pos_d[i];
        tgt_q[i] <= tgt_d[i];
      end
    end
  end

  assign jump_busy = (state_q == StCharge);
  assign jump_done = done_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_nav_position_unit.sv
// Bench for nav_position_unit: arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_nav_position_unit;

  localparam int unsigned K        = 16;
  localparam int unsigned N        = 3;
  localparam int unsigned CHARGE   = 8;
  localparam int unsigned COOLDOWN = 4;
  localparam int MaxV = 2 ** (K - 1) - 1;
  localparam int MinV = -(2 ** (K - 1));
  localparam int PhIdle = 0, PhCharge = 1, PhCool = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     ship_mode;
  logic [3:0]     pos_mode;
  logic [N*K-1:0] speed;
  logic [N*K-1:0] jump_position;
  logic           jump_req;
  logic [N*K-1:0] velocity;
  logic [N*K-1:0] position;
  logic           jump_busy;
  logic           jump_done;
  logic [N-1:0]   sat;

  int tests = 0;
  int fails = 0;

  nav_position_unit #(.K(K), .N(N), .CHARGE(CHARGE), .COOLDOWN(COOLDOWN)) dut (
    .clk(clk), .reset(reset), .ship_mode(ship_mode), .pos_mode(pos_mode),
    .speed(speed), .jump_position(jump_position), .jump_req(jump_req),
    .velocity(velocity), .position(position), .jump_busy(jump_busy),
    .jump_done(jump_done), .sat(sat)
  );

  always #5 clk = ~clk;

  function automatic int fdiv(int a, int d);
    int q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int vel_of(int s, logic [3:0] sm);
    case (sm)
      4'b0010: return s;
      4'b0100: return fdiv(s, 2);
      4'b1000: return fdiv(s, 4);
      default: return 0;
    endcase
  endfunction

  function automatic int clampv(int v);
    if (v > MaxV) return MaxV;
    if (v < MinV) return MinV;
    return v;
  endfunction

  function automatic int spd_of(int i);
    return int'($signed(speed[i*K +: K]));
  endfunction

  function automatic int px(int i);
    return int'($signed(position[i*K +: K]));
  endfunction

  function automatic int vx(int i);
    return int'($signed(velocity[i*K +: K]));
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus edges remaining in that phase.
  int           m_pos [N];
  int           m_tgt [N];
  logic [N-1:0] m_sat;
  int           m_phase;
  int           m_left;
  logic         m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) m_pos[i] <= 0;
      m_sat <= '0; m_phase <= PhIdle; m_left <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (pos_mode == 4'b0001) begin
        for (int i = 0; i < N; i++) m_pos[i] <= 0;
        m_sat <= '0; m_phase <= PhIdle;
      end else if (m_phase == PhCharge) begin
        if (m_left == 1) begin
          for (int i = 0; i < N; i++) m_pos[i] <= m_tgt[i];
          m_done  <= 1'b1;
          m_phase <= (COOLDOWN == 0) ? PhIdle : PhCool;
          m_left  <= COOLDOWN;
        end else begin
          m_left <= m_left - 1;
        end
      end else begin
        if (pos_mode == 4'b0010) begin
          for (int i = 0; i < N; i++) begin
            m_pos[i] <= clampv(m_pos[i] + vel_of(spd_of(i), ship_mode));
            if (clampv(m_pos[i] + vel_of(spd_of(i), ship_mode)) !=
                m_pos[i] + vel_of(spd_of(i), ship_mode)) m_sat[i] <= 1'b1;
          end
        end
        if (m_phase == PhIdle && jump_req) begin
          m_phase <= PhCharge;
          m_left  <= CHARGE;
          for (int i = 0; i < N; i++) m_tgt[i] <= int'($signed(jump_position[i*K +: K]));
        end else if (m_phase == PhCool) begin
          if (m_left == 1) m_phase <= PhIdle;
          m_left <= m_left - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk($sformatf("model pos[%0d]", i), px(i), m_pos[i]);
      chk($sformatf("model vel[%0d]", i), vx(i), vel_of(spd_of(i), ship_mode));
    end
    chk("model sat", int'(sat), int'(m_sat));
    chk("model busy", int'(jump_busy), int'(m_phase == PhCharge));
    chk("model done", int'(jump_done), int'(m_done));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_speed(int x, int y, int z);
    speed[0*K +: K] = K'(x);
    speed[1*K +: K] = K'(y);
    speed[2*K +: K] = K'(z);
  endtask

  task automatic set_target(int x, int y, int z);
    jump_position[0*K +: K] = K'(x);
    jump_position[1*K +: K] = K'(y);
    jump_position[2*K +: K] = K'(z);
  endtask

  initial begin
    int r;
    reset = 1'b1; ship_mode = 4'b0001; pos_mode = 4'b0010; jump_req = 1'b0;
    set_speed(0, 0, 0); set_target(0, 0, 0);
    tick(); tick();
    #1 chk("reset pos x", px(0), 0);
    chk("reset busy", int'(jump_busy), 0);
    chk("reset done", int'(jump_done), 0);
    chk("reset sat", int'(sat), 0);

    // Reset and integrate.
    reset = 1'b0; ship_mode = 4'b0010; set_speed(5, -3, 0);
    repeat (4) tick();
    #1 chk("integ x", px(0), 20);
    chk("integ y", px(1), -12);
    chk("integ z", px(2), 0);
    chk("integ sat", int'(sat), 0);

    // Mode scaling.
    pos_mode = 4'b0100; set_speed(7, -3, -8); ship_mode = 4'b0100;
    #1 chk("def vx", vx(0), 3); chk("def vy", vx(1), -2); chk("def vz", vx(2), -4);
    ship_mode = 4'b1000;
    #1 chk("stl vx", vx(0), 1); chk("stl vy", vx(1), -1); chk("stl vz", vx(2), -2);
    ship_mode = 4'b0011;
    #1 chk("bad vx", vx(0), 0); chk("bad vy", vx(1), 0); chk("bad vz", vx(2), 0);

    // Saturation.
    tick(); pos_mode = 4'b0001; tick();
    pos_mode = 4'b0010; ship_mode = 4'b0010; set_speed(32760, 0, 0); tick();
    set_speed(10, 0, 0); tick();
    #1 chk("sat clamp x", px(0), 32767); chk("sat bit", int'(sat), 1);
    set_speed(-10, 0, 0); tick();
    #1 chk("sat back x", px(0), 32757); chk("sat sticky", int'(sat), 1);
    pos_mode = 4'b0001; tick();
    #1 chk("zero x", px(0), 0); chk("zero sat", int'(sat), 0);

    // Jump handshake.
    pos_mode = 4'b0010; set_speed(99, 0, 0); tick();
    set_speed(1, 0, 0); jump_req = 1'b1; set_target(-500, 300, -7); tick();
    jump_req = 1'b0; set_target(1234, -1234, 55);
    for (int i = 0; i < int'(CHARGE); i++) begin
      #1 chk("charge busy", int'(jump_busy), 1);
      chk("charge hold x", px(0), 100);
      tick();
    end
    #1 chk("jump x", px(0), -500); chk("jump y", px(1), 300);
    chk("jump done", int'(jump_done), 1); chk("jump busy off", int'(jump_busy), 0);
    tick();
    #1 chk("after x", px(0), -499); chk("done pulse", int'(jump_done), 0);
    jump_req = 1'b1; tick(); jump_req = 1'b0;
    #1 chk("cool ignore busy", int'(jump_busy), 0); chk("cool x", px(0), -498);
    repeat (4) tick();

    // Abort by zero mode at charge cycle 3.
    jump_req = 1'b1; tick(); jump_req = 1'b0; tick(); tick();
    pos_mode = 4'b0001; tick();
    #1 chk("abort x", px(0), 0); chk("abort busy", int'(jump_busy), 0);
    chk("abort done", int'(jump_done), 0);
    pos_mode = 4'b0010; set_speed(0, 0, 0); repeat (CHARGE) tick();
    #1 chk("abort no done", int'(jump_done), 0); chk("abort hold x", px(0), 0);

    // Asynchronous reset mid-charge.
    set_speed(3, 3, 3); jump_req = 1'b1; tick(); jump_req = 1'b0; tick();
    #2 reset = 1'b1;
    #1 chk("areset x", px(0), 0); chk("areset busy", int'(jump_busy), 0);
    tick(); reset = 1'b0;

    // Hold and invalid position mode.
    set_speed(9, 9, 9); tick();
    pos_mode = 4'b0100; tick(); tick();
    #1 chk("hold x", px(0), 9); chk("hold y", px(1), 9);
    pos_mode = 4'b0110; tick();
    #1 chk("inv hold x", px(0), 9); chk("inv hold z", px(2), 9);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 9));
      ship_mode = (r < 8) ? (4'b0001 << (r % 4)) : 4'($urandom);
      r = int'($urandom_range(0, 99));
      pos_mode = (r < 3) ? 4'b0001 : (r < 75) ? 4'b0010 : (r < 90) ? 4'b0100 : 4'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 0) speed[i*K +: K] = K'(int'($urandom_range(0, 100)) - 50);
        else speed[i*K +: K] = K'($urandom);
        jump_position[i*K +: K] = K'($urandom);
      end
      jump_req = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
